nibble_add_sequencer: RTL and testbench



---
 rtl/nibble_add_pkg.sv | 19 +
 rtl/nibble_add_sequencer_if.sv | 53 +++++
 rtl/nibble_add_sequencer_csel_add4.sv | 33 +++
 rtl/nibble_add_sequencer.sv | 127 ++++++++++++
 tb/tb_nibble_add_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_add_pkg.sv
// Shared types and helpers for the serial nibble adder.
// Optional subtract mode is enabled by NIBBLE_ADD_SUB_EN.
package nibble_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int width);
    int n;
    n = width / SLICE_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// Operand/result handshake bundle for nibble_add_sequencer.
// NIBBLE_ADD_SUB_EN adds the sub request bit.
interface nibble_add_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_ADD_SUB_EN
  logic             sub;
`endif

  modport master (
`ifdef NIBBLE_ADD_SUB_EN
    output sub,
`endif
    output in_valid,
    output op_a,
    output op_b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  busy
  );

  modport slave (
`ifdef NIBBLE_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid,
    input  op_a,
    input  op_b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output busy
  );

endinterface

// File: rtl/nibble_add_sequencer_csel_add4.sv
// 4-bit carry-select slice: both carry-in cases ripple in
// parallel, the real carry-in only picks the result.
module csel_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] w_c0;
  logic [4:0] w_c1;
  logic [3:0] w_s0;
  logic [3:0] w_s1;

  always_comb begin
    w_c0    = '0;
    w_c1    = '0;
    w_s0    = '0;
    w_s1    = '0;
    w_c1[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_s0[i]   = a[i] ^ b[i] ^ w_c0[i];
      w_c0[i+1] = (a[i] & b[i]) | (w_c0[i] & (a[i] ^ b[i]));
      w_s1[i]   = a[i] ^ b[i] ^ w_c1[i];
      w_c1[i+1] = (a[i] & b[i]) | (w_c1[i] & (a[i] ^ b[i]));
    end
  end

  assign s  = ci ? w_s1 : w_s0;
  assign co = ci ? w_c1[4] : w_c0[4];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Serial WIDTH-bit adder: one shared 4-bit slice, LSB nibble first.
// Define NIBBLE_ADD_SUB_EN for the A-B mode via the sub bit.
module nibble_add_sequencer
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  nibble_add_sequencer_if.slave bus
);

  localparam int NS = WIDTH / SLICE_W;
  localparam int IW = idx_width(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_RUN  = 2'(S_RUN);
  localparam logic [1:0] ST_DONE = 2'(S_DONE);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("nibble_add_sequencer: WIDTH must be a multiple of 4, >= 4");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IW-1:0]    r_idx;
`ifdef NIBBLE_ADD_SUB_EN
  logic             r_sub;
`endif

  logic [3:0] w_an;
  logic [3:0] w_bn;
  logic [3:0] w_s;
  logic       w_co;
  logic       w_last;
  logic       w_acc;
  logic       w_cin0;

  always_comb begin
    w_an = '0;
    w_bn = '0;
    for (int i = 0; i < NS; i++) begin
      if (r_idx == IW'(i)) begin
        w_an = r_a[i*SLICE_W +: SLICE_W];
        w_bn = r_b[i*SLICE_W +: SLICE_W];
      end
    end
`ifdef NIBBLE_ADD_SUB_EN
    if (r_sub) w_bn = ~w_bn;
`endif
  end

`ifdef NIBBLE_ADD_SUB_EN
  // Two's complement: invert B, inject the +1 as the first carry.
  assign w_cin0 = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_cin0 = bus.cin;
`endif

  assign w_last = (r_idx == IW'(NS - 1));
  assign w_acc  = bus.in_valid && (r_state == ST_IDLE);

  csel_add4 u_slice (
    .a  (w_an),
    .b  (w_bn),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
`ifdef NIBBLE_ADD_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_carry <= w_cin0;
            r_idx   <= '0;
`ifdef NIBBLE_ADD_SUB_EN
            r_sub   <= bus.sub;
`endif
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NS; i++) begin
            if (r_idx == IW'(i)) r_sum[i*SLICE_W +: SLICE_W] <= w_s;
          end
          r_carry <= w_co;
          if (w_last) begin
            r_cout  <= w_co;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer (WIDTH=16 and WIDTH=4).
// Subtract vectors run only when NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_add_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nibble_add_sequencer_if #(.WIDTH(16)) b16 ();
  nibble_add_sequencer_if #(.WIDTH(4))  b4 ();

  nibble_add_sequencer #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16.slave)
  );

  nibble_add_sequencer #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  task automatic accept16(input logic [15:0] a, input logic [15:0] b,
                          input logic c);
    b16.op_a     = a;
    b16.op_b     = b;
    b16.cin      = c;
    b16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    while (b16.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic release16();
    b16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 ||
        b16.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl16: rdy=%b vld=%b busy=%b want 1 0 0",
               b16.in_ready, b16.out_valid, b16.busy);
    end
    checks++;
    if (b16.sum !== 16'h0000 || b16.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_data16: sum=%h cout=%b want 0000 0",
               b16.sum, b16.cout);
    end
    checks++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 ||
        b4.sum !== 4'h0 || b4.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_w4: rdy=%b vld=%b sum=%h cout=%b want 1 0 0 0",
               b4.in_ready, b4.out_valid, b4.sum, b4.cout);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_add();
    accept16(16'h1234, 16'h0FFF, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (b16.in_ready !== 1'b0 || b16.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_rdy_k%0d: rdy=%b busy=%b want 0 1",
                 k, b16.in_ready, b16.busy);
      end
      if (k == 4) begin
        checks++;
        if (b16.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid: got %b want 0", b16.out_valid);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (b16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b want 1 after 4 edges",
               b16.out_valid);
    end
    checks++;
    if (b16.sum !== 16'h2233 || b16.cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: sum=%h cout=%b want 2233 0",
               b16.sum, b16.cout);
    end
    release16();
    checks++;
    if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: vld=%b rdy=%b want 0 1",
               b16.out_valid, b16.in_ready);
    end
  endtask

  task automatic test_carry_ripple();
    int n;
    accept16(16'hFFFF, 16'h0001, 1'b0);
    wait_done16(n);
    checks++;
    if (n != 4 || b16.sum !== 16'h0000 || b16.cout !== 1'b1) begin
      errors++;
      $display("FAIL ripple_ffff: edges=%0d sum=%h cout=%b want 4 0000 1",
               n, b16.sum, b16.cout);
    end
    release16();
    accept16(16'h0000, 16'h0000, 1'b1);
    wait_done16(n);
    checks++;
    if (n != 4 || b16.sum !== 16'h0001 || b16.cout !== 1'b0) begin
      errors++;
      $display("FAIL ripple_cin: edges=%0d sum=%h cout=%b want 4 0001 0",
               n, b16.sum, b16.cout);
    end
    release16();
  endtask

  task automatic test_backpressure();
    int n;
    accept16(16'h00FF, 16'h0001, 1'b0);
    wait_done16(n);
    for (int k = 0; k < 3; k++) begin
      b16.op_a     = 16'h7777;
      b16.op_b     = 16'h1111;
      b16.in_valid = 1'b1;
      @(posedge clk);
      #1;
      b16.in_valid = 1'b0;
      checks++;
      if (b16.out_valid !== 1'b1 || b16.in_ready !== 1'b0 ||
          b16.sum !== 16'h0100 || b16.cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_k%0d: vld=%b rdy=%b sum=%h cout=%b want 1 0 0100 0",
                 k, b16.out_valid, b16.in_ready, b16.sum, b16.cout);
      end
    end
    release16();
    checks++;
    if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 ||
        b16.sum !== 16'h0100) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b sum=%h want 0 1 0100",
               b16.out_valid, b16.in_ready, b16.sum);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b16.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_latch: busy=%b want 0", b16.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    accept16(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b16.out_valid !== 1'b0 || b16.sum !== 16'h0000 ||
        b16.in_ready !== 1'b1 || b16.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: vld=%b sum=%h rdy=%b busy=%b want 0 0000 1 0",
               b16.out_valid, b16.sum, b16.in_ready, b16.busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (b16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_pulse: vld=%b want 0", b16.out_valid);
    end
    accept16(16'h0001, 16'h0001, 1'b0);
    wait_done16(n);
    checks++;
    if (n != 4 || b16.sum !== 16'h0002 || b16.cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_next_op: edges=%0d sum=%h cout=%b want 4 0002 0",
               n, b16.sum, b16.cout);
    end
    release16();
  endtask

  task automatic test_width4();
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic       vc [3];
    logic [3:0] es [3];
    logic       ec [3];
    va = '{4'hF, 4'h7, 4'h3};
    vb = '{4'h1, 4'h8, 4'h4};
    vc = '{1'b0, 1'b1, 1'b0};
    es = '{4'h0, 4'h0, 4'h7};
    ec = '{1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      b4.op_a     = va[v];
      b4.op_b     = vb[v];
      b4.cin      = vc[v];
      b4.in_valid = 1'b1;
      @(posedge clk);
      #1;
      b4.in_valid = 1'b0;
      checks++;
      if (b4.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL w4_early_v%0d: vld=%b want 0", v, b4.out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (b4.out_valid !== 1'b1 || b4.sum !== es[v] || b4.cout !== ec[v]) begin
        errors++;
        $display("FAIL w4_v%0d: vld=%b sum=%h cout=%b want 1 %h %b",
                 v, b4.out_valid, b4.sum, b4.cout, es[v], ec[v]);
      end
      b4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      b4.out_ready = 1'b0;
    end
  endtask

`ifdef NIBBLE_ADD_SUB_EN
  task automatic test_sub();
    int n;
    b16.sub = 1'b1;
    accept16(16'h0005, 16'h0007, 1'b0);
    b16.sub = 1'b0;
    wait_done16(n);
    checks++;
    if (n != 4 || b16.sum !== 16'hFFFE || b16.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: edges=%0d sum=%h cout=%b want 4 fffe 0",
               n, b16.sum, b16.cout);
    end
    release16();
    b16.sub = 1'b1;
    accept16(16'h0007, 16'h0005, 1'b0);
    b16.sub = 1'b0;
    wait_done16(n);
    checks++;
    if (n != 4 || b16.sum !== 16'h0002 || b16.cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: edges=%0d sum=%h cout=%b want 4 0002 1",
               n, b16.sum, b16.cout);
    end
    release16();
  endtask
`endif

  initial begin
    b16.in_valid  = 1'b0;
    b16.op_a      = '0;
    b16.op_b      = '0;
    b16.cin       = 1'b0;
    b16.out_ready = 1'b0;
    b4.in_valid   = 1'b0;
    b4.op_a       = '0;
    b4.op_b       = '0;
    b4.cin        = 1'b0;
    b4.out_ready  = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
    b16.sub       = 1'b0;
    b4.sub        = 1'b0;
`endif
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
`ifdef NIBBLE_ADD_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
